// File: rtl/vae_anomaly_scorer.sv
// Scores one VAE frame: buffers N_FEAT original features, accumulates the squared
// reconstruction error through a 3-stage pipeline, and emits a single 64-bit verdict word.
module vae_anomaly_scorer #(
    parameter int N_FEAT = 9,
    parameter int SHIFT  = 0,
    parameter int CNT_W  = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [63:0] s_x_tdata,
    input  logic        s_x_tvalid,
    input  logic        s_x_tlast,
    output logic        s_x_tready,
    input  logic [63:0] s_r_tdata,
    input  logic        s_r_tvalid,
    input  logic        s_r_tlast,
    output logic        s_r_tready,
    input  logic [31:0] threshold,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        busy
);

    typedef enum logic [1:0] {LOAD_X, ACC, FLUSH, OUT} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   idx_reg;
    logic [15:0]        xbuf [N_FEAT];
    logic signed [16:0] diff_reg;
    logic               v1_reg;
    logic [33:0]        sq_reg;
    logic               v2_reg;
    logic [36:0]        acc_reg;
    logic               err_reg;
    logic [15:0]        frame_cnt_reg;
    logic [63:0]        tdata_reg;

    logic               x_fire, r_fire, out_fire, last_beat, tlast_in, flush_done;
    logic [15:0]        x_sel;
    logic signed [16:0] diff_next;
    logic signed [33:0] prod;
    logic [36:0]        shifted;
    logic [31:0]        score;
    logic               anomaly;

    // Fire signals depend only on registered state, never on a ready output.
    assign x_fire     = s_x_tvalid && (state_reg == LOAD_X);
    assign r_fire     = s_r_tvalid && (state_reg == ACC);
    assign out_fire   = m_axis_tready && (state_reg == OUT);
    assign last_beat  = (idx_reg == LAST_IDX);
    assign tlast_in   = (state_reg == ACC) ? s_r_tlast : s_x_tlast;
    assign flush_done = (state_reg == FLUSH) && !v1_reg && !v2_reg;

    assign x_sel     = xbuf[idx_reg];
    assign diff_next = $signed({s_r_tdata[63], s_r_tdata[63:48]}) - $signed({x_sel[15], x_sel});
    assign prod      = 34'(diff_reg) * 34'(diff_reg);

    assign shifted = acc_reg >> SHIFT;
    assign score   = (|shifted[36:32]) ? 32'hFFFF_FFFF : shifted[31:0];
    assign anomaly = (score > threshold);

    genvar gi;
    generate
        for (gi = 0; gi < N_FEAT; gi++) begin : g_xbuf
            logic [15:0] word_reg;
            always_ff @(posedge aclk) begin
                if (x_fire && idx_reg == CNT_W'(gi))
                    word_reg <= s_x_tdata[63:48];
            end
            assign xbuf[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) state_reg <= LOAD_X;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        s_x_tready    = 1'b0;
        s_r_tready    = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_reg)
            LOAD_X: begin
                s_x_tready = 1'b1;
                if (x_fire && last_beat) state_next = ACC;
            end
            ACC: begin
                s_r_tready = 1'b1;
                if (r_fire && last_beat) state_next = FLUSH;
            end
            FLUSH: begin
                if (flush_done) state_next = OUT;
            end
            OUT: begin
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) state_next = LOAD_X;
            end
            default: state_next = LOAD_X;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            idx_reg       <= '0;
            diff_reg      <= '0;
            v1_reg        <= 1'b0;
            sq_reg        <= '0;
            v2_reg        <= 1'b0;
            acc_reg       <= '0;
            err_reg       <= 1'b0;
            frame_cnt_reg <= '0;
            tdata_reg     <= '0;
        end else begin
            v1_reg <= r_fire;
            if (r_fire) diff_reg <= diff_next;
            v2_reg <= v1_reg;
            if (v1_reg) sq_reg <= unsigned'(prod);
            if (v2_reg) acc_reg <= acc_reg + 37'(sq_reg);

            // Framing errors are only flagged; the beat count always runs to N_FEAT.
            if (x_fire || r_fire) begin
                idx_reg <= last_beat ? '0 : idx_reg + 1'b1;
                if (tlast_in != last_beat) err_reg <= 1'b1;
            end

            if (flush_done)
                tdata_reg <= {anomaly, err_reg, 14'd0, frame_cnt_reg, score};

            if (out_fire) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                acc_reg       <= '0;
                err_reg       <= 1'b0;
            end
        end
    end

    assign m_axis_tdata = tdata_reg;
    assign m_axis_tlast = m_axis_tvalid;
    assign busy         = !((state_reg == LOAD_X) && (idx_reg == '0));

endmodule

// File: tb/tb_vae_anomaly_scorer.sv
// Directed plus randomized bench for vae_anomaly_scorer; expected words come from
// a frame-level arithmetic model (sum of squared errors, saturate, threshold).
module tb_vae_anomaly_scorer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] s_x_tdata, s_r_tdata;
    logic        s_x_tvalid, s_x_tlast, s_x_tready;
    logic        s_r_tvalid, s_r_tlast, s_r_tready;
    logic [31:0] thr;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic        busy;

    vae_anomaly_scorer dut (
        .aclk(aclk), .areset(areset),
        .s_x_tdata(s_x_tdata), .s_x_tvalid(s_x_tvalid), .s_x_tlast(s_x_tlast), .s_x_tready(s_x_tready),
        .s_r_tdata(s_r_tdata), .s_r_tvalid(s_r_tvalid), .s_r_tlast(s_r_tlast), .s_r_tready(s_r_tready),
        .threshold(thr),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int cycle = 0;
    always @(posedge aclk) cycle <= cycle + 1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] xs_a [9];
    logic [15:0] rs_a [9];
    logic [8:0]  xlast_m, rlast_m;
    int          exp_frame;

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: plain integer arithmetic over the whole frame.
    function automatic logic [63:0] model_word();
        longint      sum = 0;
        longint      d;
        logic [31:0] sc;
        logic        err, an;
        for (int i = 0; i < 9; i++) begin
            d   = longint'($signed(rs_a[i])) - longint'($signed(xs_a[i]));
            sum = sum + d * d;
        end
        sc  = (sum > 64'd4294967295) ? 32'hFFFF_FFFF : sum[31:0];
        err = (xlast_m != 9'h100) || (rlast_m != 9'h100);
        an  = (sc > thr);
        return {an, err, 14'd0, exp_frame[15:0], sc};
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        s_x_tvalid = 1'b0; s_r_tvalid = 1'b0; m_axis_tready = 1'b0;
        repeat (2) cyc();
        areset = 1'b0;
        exp_frame = 0;
    endtask

    task automatic send_beat(input bit is_r, input logic [15:0] v, input logic last,
                             input bit gaps, output int hs);
        int tmo = 0;
        if (gaps) repeat ($urandom_range(0, 2)) cyc();
        if (is_r) begin
            s_r_tdata = {v, 16'($urandom), 32'($urandom)}; s_r_tlast = last; s_r_tvalid = 1'b1;
        end else begin
            s_x_tdata = {v, 16'($urandom), 32'($urandom)}; s_x_tlast = last; s_x_tvalid = 1'b1;
        end
        while (!(is_r ? s_r_tready : s_x_tready) && tmo < 200) begin
            cyc();
            tmo++;
        end
        if (tmo >= 200) check(is_r ? "r_ready_timeout" : "x_ready_timeout", 64'(tmo), 64'd0);
        hs = cycle;
        cyc();
        s_x_tvalid = 1'b0;
        s_r_tvalid = 1'b0;
    endtask

    task automatic run_frame(input bit gaps, input int hold, output logic [63:0] word);
        int          hs, tmo;
        bit          x_ok, stable;
        logic [63:0] held;
        for (int i = 0; i < 9; i++) begin
            send_beat(1'b0, xs_a[i], xlast_m[i], gaps, hs);
            if (i == 0) check("busy_after_x0", 64'(busy), 64'd1);
        end
        for (int i = 0; i < 9; i++) send_beat(1'b1, rs_a[i], rlast_m[i], gaps, hs);
        tmo = 0; x_ok = 1'b1;
        while (!m_axis_tvalid && tmo < 50) begin
            if (s_x_tready) x_ok = 1'b0;
            cyc();
            tmo++;
        end
        check("latency", 64'(cycle - hs), 64'd4);
        check("tlast", 64'(m_axis_tlast), 64'd1);
        held = m_axis_tdata; stable = 1'b1;
        repeat (hold) begin
            cyc();
            if (!m_axis_tvalid || m_axis_tdata !== held || s_x_tready) stable = 1'b0;
        end
        check("hold_stable", 64'(stable), 64'd1);
        check("x_blocked", 64'(x_ok), 64'd1);
        check("word", m_axis_tdata, model_word());
        word = m_axis_tdata;
        m_axis_tready = 1'b1;
        cyc();
        m_axis_tready = 1'b0;
        check("one_word", 64'(m_axis_tvalid), 64'd0);
        exp_frame = (exp_frame + 1) & 16'hFFFF;
        $display("frame done: word=%h cycle=%0d", word, cycle);
    endtask

    task automatic fill(input logic [15:0] xv, input logic [15:0] rv);
        for (int i = 0; i < 9; i++) begin xs_a[i] = xv; rs_a[i] = rv; end
        xlast_m = 9'h100; rlast_m = 9'h100;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 9; i++) begin
            xs_a[i] = 16'($urandom);
            rs_a[i] = xs_a[i] + 16'($urandom_range(0, 1023)) - 16'd512;
        end
        xlast_m = 9'h100; rlast_m = 9'h100;
    endtask

    initial begin
        logic [63:0] w;
        int          hs;
        bit          quiet;
        s_x_tdata = '0; s_r_tdata = '0; s_x_tlast = 1'b0; s_r_tlast = 1'b0; thr = '0;
        do_reset();
        check("rst_x_ready", 64'(s_x_tready), 64'd1);
        check("rst_r_ready", 64'(s_r_tready), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        fill(16'h1234, 16'h1234); thr = 32'd0;
        run_frame(1'b0, 0, w);
        check("identical", w, 64'h0000_0000_0000_0000);

        fill(16'h0100, 16'h0180); thr = 32'h0002_0000;
        run_frame(1'b0, 0, w);
        check("score_24000_hi", w, 64'h8000_0001_0002_4000);
        thr = 32'h0002_4000;
        run_frame(1'b0, 0, w);
        check("score_24000_eq", w, 64'h0000_0002_0002_4000);

        fill(16'h8000, 16'h7FFF); thr = 32'hFFFF_FFFE;
        run_frame(1'b0, 0, w);
        check("sat_anom", w, 64'h8000_0003_FFFF_FFFF);
        thr = 32'hFFFF_FFFF;
        run_frame(1'b0, 0, w);
        check("sat_noanom", w, 64'h0000_0004_FFFF_FFFF);

        do_reset();
        fill_random(); rlast_m = 9'h010; thr = $urandom_range(0, 200000);
        run_frame(1'b0, 0, w);
        check("framing_err", 64'(w[62]), 64'd1);
        fill_random(); thr = $urandom_range(0, 200000);
        run_frame(1'b0, 0, w);
        check("clean_err", 64'(w[62]), 64'd0);
        check("clean_cnt", 64'(w[47:32]), 64'd1);

        for (int k = 0; k < 6; k++) begin
            fill_random(); thr = $urandom_range(0, 600000);
            run_frame(1'b1, (k == 0) ? 20 : int'($urandom_range(0, 5)), w);
        end

        fill_random();
        for (int i = 0; i < 9; i++) send_beat(1'b0, xs_a[i], xlast_m[i], 1'b0, hs);
        for (int i = 0; i < 5; i++) send_beat(1'b1, rs_a[i], rlast_m[i], 1'b1, hs);
        do_reset();
        quiet = 1'b1;
        repeat (12) begin
            if (m_axis_tvalid) quiet = 1'b0;
            cyc();
        end
        check("no_spurious", 64'(quiet), 64'd1);
        check("reset_x_ready", 64'(s_x_tready), 64'd1);
        fill_random(); thr = $urandom_range(0, 200000);
        run_frame(1'b0, 2, w);
        check("post_reset_cnt", 64'(w[47:32]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
